// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: default widths, frame header
// value and the 3-bit FSM state encoding.
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam logic [7:0] DEF_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2^W sum of a frame's data bytes. The zero flag reports
// whether the sum plus the byte currently presented on din is zero, so the
// checksum byte can be judged in the same cycle it is accepted.
module loader_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         add_en,
  input  logic [W-1:0] din,
  output logic         zero
);

  logic [W-1:0] sum;
  logic [W-1:0] total;

  // Accumulate accepted data bytes; clear at the start of each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

  // Sum including the presented byte, truncated to W bits.
  always_comb begin
    total = sum + din;
    zero  = (total == '0);
  end

endmodule

// File: rtl/prog_loader.sv
// Program memory loader: takes a framed byte stream (HEADER, LEN_HI, LEN_LO,
// data..., optional CHK) and writes the data sequentially from address 0,
// holding the processor in reset while loading or after a failed load.
// Optional checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HEADER = DEF_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int HI_W = ADDR_W - 8;

  state_t            state, state_next;
  logic              xfer;
  logic              is_header;
  logic              len_hi_bad;
  logic              last_byte;
  logic              frame_start;
  logic              chk_zero;
  logic [HI_W-1:0]   len_hi;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] len_m1;

  // The loader stalls the link only during the write-strobe cycle.
  assign rx_ready    = ~mem_we;
  assign xfer        = rx_valid & rx_ready;
  assign is_header   = (rx_data == HEADER);
  assign len_hi_bad  = (rx_data[DATA_W-1:HI_W] != '0);
  // Length 0 encodes a full 2**ADDR_W frame, which falls out of the wrap of len-1.
  assign len_m1      = len - {{(ADDR_W-1){1'b0}}, 1'b1};
  // The write address of the byte being accepted equals its index in the frame.
  assign last_byte   = (mem_addr == len_m1);
  assign frame_start = xfer && is_header &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  loader_checksum #(.W(DATA_W)) u_checksum (
    .clk    (clk),
    .reset  (reset),
    .clear  (frame_start),
    .add_en (xfer && (state == ST_DATA)),
    .din    (rx_data),
    .zero   (chk_zero)
  );

`ifndef PROG_LOADER_CHECKSUM_EN
  logic unused_chk_zero;
  assign unused_chk_zero = chk_zero;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; every transition is qualified by an accepted transfer.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    if (xfer) begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: if (is_header) state_next = ST_LEN_HI;
        ST_LEN_HI:                state_next = len_hi_bad ? ST_ERR : ST_LEN_LO;
        ST_LEN_LO:                state_next = ST_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_DATA:                  if (last_byte) state_next = ST_CHK;
        ST_CHK:                   state_next = chk_zero ? ST_DONE : ST_ERR;
`else
        ST_DATA:                  if (last_byte) state_next = ST_DONE;
`endif
        default:                  state_next = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from state; done/error are sticky because only a
  // HEADER leaves DONE/ERR.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      ST_IDLE: cpu_hold = 1'b0;
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Length capture, write register and address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      len_hi    <= '0;
      len       <= '0;
    end else begin
      mem_we <= 1'b0;
      // Advance after each write; transfers never coincide with mem_we.
      if (mem_we) mem_addr <= mem_addr + 1'b1;
      if (xfer) begin
        unique case (state)
          ST_IDLE, ST_DONE, ST_ERR: if (is_header) mem_addr <= '0;
          ST_LEN_HI: len_hi <= rx_data[HI_W-1:0];
          ST_LEN_LO: len    <= {len_hi, rx_data};
          ST_DATA: begin
            mem_wdata <= rx_data;
            mem_we    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader; follows PROG_LOADER_CHECKSUM_EN so the
// same bench covers both builds.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       mem_we;
  logic [11:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [4096];
  int wr_count  = 0;
  int last_addr = -1;
  int ready_viol = 0;
  int ready_low  = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Program memory model fed by the write port.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
      last_addr     <= int'(mem_addr);
    end
  end

  // Link handshake observations, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we && rx_ready) ready_viol <= ready_viol + 1;
    if (!rx_ready)          ready_low  <= ready_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and wait (bounded) until it is accepted; rx_valid stays high.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int wr0, rl0, bad;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    wait_cycles(1);

    // Clean 3-byte frame
    send(8'hA5);
    check("f1_hold_on", 32'(cpu_hold), 32'd1);
    check("f1_busy_on", 32'(busy), 32'd1);
    send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h9A);
`endif
    rx_valid = 1'b0;
    wait_cycles(2);
    check("f1_mem0", 32'(mem[0]), 32'h11);
    check("f1_mem1", 32'(mem[1]), 32'h22);
    check("f1_mem2", 32'(mem[2]), 32'h33);
    check("f1_writes", 32'(wr_count), 32'd3);
    check("f1_addr", 32'(mem_addr), 32'd3);
    check("f1_done", 32'(done), 32'd1);
    check("f1_hold_off", 32'(cpu_hold), 32'd0);
    check("f1_error", 32'(error), 32'd0);
    check("f1_busy_off", 32'(busy), 32'd0);

    // Two-byte frame followed by 00: bad checksum, or a dropped byte without one
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h00);
    rx_valid = 1'b0;
    wait_cycles(2);
    check("f2_mem0", 32'(mem[0]), 32'h10);
    check("f2_mem1", 32'(mem[1]), 32'h20);
    check("f2_writes", 32'(wr_count), 32'd5);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("f2_error", 32'(error), 32'd1);
    check("f2_hold", 32'(cpu_hold), 32'd1);
    check("f2_done", 32'(done), 32'd0);
`else
    check("f2_error", 32'(error), 32'd0);
    check("f2_hold", 32'(cpu_hold), 32'd0);
    check("f2_done", 32'(done), 32'd1);
`endif

    // LEN_HI with upper nibble set -> ERR immediately, no writes
    send(8'hA5); send(8'h10);
    rx_valid = 1'b0;
    wait_cycles(2);
    check("f3_error", 32'(error), 32'd1);
    check("f3_hold", 32'(cpu_hold), 32'd1);
    check("f3_busy", 32'(busy), 32'd0);
    check("f3_done", 32'(done), 32'd0);
    check("f3_writes", 32'(wr_count), 32'd5);

    // Recovery frame
    send(8'hA5); send(8'h00); send(8'h01); send(8'h5A);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hA6);
`endif
    rx_valid = 1'b0;
    wait_cycles(2);
    check("f4_done", 32'(done), 32'd1);
    check("f4_error", 32'(error), 32'd0);
    check("f4_mem0", 32'(mem[0]), 32'h5A);
    check("f4_writes", 32'(wr_count), 32'd6);

    // Full 4096-byte frame (length 0); checksum of the pattern is 0x00
    wr0 = wr_count;
    send(8'hA5); send(8'h00); send(8'h00);
    for (int i = 0; i < 4096; i++) send(8'(i));
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    rx_valid = 1'b0;
    wait_cycles(2);
    check("f5_writes", 32'(wr_count - wr0), 32'd4096);
    check("f5_last_addr", 32'(last_addr), 32'hFFF);
    check("f5_addr_wrap", 32'(mem_addr), 32'd0);
    check("f5_done", 32'(done), 32'd1);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== 8'(i)) bad++;
    check("f5_content_bad", 32'(bad), 32'd0);

    // Reset after the 2nd data byte of a 5-byte frame
    wr0 = wr_count;
    send(8'hA5); send(8'h00); send(8'h05); send(8'h01); send(8'h02);
    rx_valid = 1'b0;
    wait_cycles(1);
    #2 reset = 1'b1;
    #1;
    check("mr_rx_ready", 32'(rx_ready), 32'd1);
    check("mr_mem_we", 32'(mem_we), 32'd0);
    check("mr_mem_addr", 32'(mem_addr), 32'd0);
    check("mr_mem_wdata", 32'(mem_wdata), 32'd0);
    check("mr_cpu_hold", 32'(cpu_hold), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_error", 32'(error), 32'd0);
    check("mr_kept0", 32'(mem[0]), 32'h01);
    check("mr_kept1", 32'(mem[1]), 32'h02);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(1);
    send(8'h3C);
    rx_valid = 1'b0;
    wait_cycles(2);
    check("ig_busy", 32'(busy), 32'd0);
    check("ig_hold", 32'(cpu_hold), 32'd0);
    check("ig_done", 32'(done), 32'd0);
    check("ig_writes", 32'(wr_count - wr0), 32'd2);

    // rx_valid held high through DATA: one stall cycle and one write per byte
    wr0 = wr_count;
    rl0 = ready_low;
    send(8'hA5); send(8'h00); send(8'h04);
    send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hB6);
`endif
    rx_valid = 1'b0;
    wait_cycles(2);
    check("cv_writes", 32'(wr_count - wr0), 32'd4);
    check("cv_stalls", 32'(ready_low - rl0), 32'd4);
    check("cv_ready_viol", 32'(ready_viol), 32'd0);
    check("cv_mem0", 32'(mem[0]), 32'hD1);
    check("cv_mem3", 32'(mem[3]), 32'hD4);
    check("cv_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
